// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic datapath blocks.
package arith_pkg;

  // Operand width used when a block is instantiated without overriding WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Control states of the bit-serial arithmetic units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor built from gate primitives.
// d = x - y - bin (mod 2); bout is set when x < y + bin.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire w_xy;
  wire w_notX;
  wire w_notXy;
  wire w_genBorrow;
  wire w_propBorrow;

  xor g_xy    (w_xy, x, y);
  xor g_diff  (d, w_xy, bin);
  not g_notX  (w_notX, x);
  and g_gen   (w_genBorrow, w_notX, y);
  not g_notXy (w_notXy, w_xy);
  and g_prop  (w_propBorrow, w_notXy, bin);
  or  g_bout  (bout, w_genBorrow, w_propBorrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// A controller pulses start in IDLE, waits for done, then reads diff/borrow_out,
// which stay stable until the next operation completes.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_resSh;
  logic [WIDTH-1:0] r_diff;
  logic             r_brw;
  logic             r_borrowOut;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bo;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_resNext;

  full_sub_cell u_cell (
    .x   (r_aSh[0]),
    .y   (r_bSh[0]),
    .bin (r_brw),
    .d   (w_d),
    .bout(w_bo)
  );

  assign w_lastBit = (r_cnt == LAST_CNT);
  assign w_resNext = (r_resSh >> 1) | {w_d, {(WIDTH-1){1'b0}}};
  assign diff       = r_diff;
  assign borrow_out = r_borrowOut;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode and handshake outputs; start is only honoured in IDLE.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (start) w_nextState = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_lastBit) w_nextState = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_resSh <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_aSh <= a;
            r_bSh <= b;
            r_brw <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_aSh   <= r_aSh >> 1;
          r_bSh   <= r_bSh >> 1;
          r_resSh <= w_resNext;
          r_brw   <= w_bo;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final RUN edge so they are valid during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff      <= '0;
      r_borrowOut <= 1'b0;
    end else if (r_state == RUN && w_lastBit) begin
      r_diff      <= w_resNext;
      r_borrowOut <= w_bo;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy8, done8, bo8;
  logic        busy16, done16, bo16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation on the selected DUT and wait (bounded) for done.
  // lat counts negedges after the cycle in which start was raised.
  task automatic applyStimulus(input int w, input logic [15:0] av, input logic [15:0] bv,
                               output logic [15:0] dOut, output logic boOut, output int lat,
                               output logic busyFirst, output logic doneAfter);
    logic doneNow;
    @(negedge clk);
    if (w == 8) begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; end
    else        begin start16 = 1'b1; a16 = av; b16 = bv; end
    lat = 0;
    busyFirst = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        busyFirst = (w == 8) ? busy8 : busy16;
        start8 = 1'b0;
        start16 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      doneNow = (w == 8) ? done8 : done16;
    end while (!doneNow && lat < 200);
    dOut  = (w == 8) ? {8'h00, diff8} : diff16;
    boOut = (w == 8) ? bo8 : bo16;
    @(negedge clk);
    doneAfter = (w == 8) ? done8 : done16;
  endtask

  initial begin
    logic [15:0] d;
    logic        bo, busyFirst, doneAfter;
    int          lat;
    int          ai, bi, mask, expDiff;
    logic [15:0] av, bv;

    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy8", busy8, 0);
    checkOutput("rst_done8", done8, 0);
    checkOutput("rst_diff8", diff8, 0);
    checkOutput("rst_bo8", bo8, 0);
    checkOutput("rst_busy16", busy16, 0);
    checkOutput("rst_diff16", diff16, 0);
    rst_n = 1'b1;

    applyStimulus(8, 16'h5A, 16'h23, d, bo, lat, busyFirst, doneAfter);
    checkOutput("t1_busy", busyFirst, 1);
    checkOutput("t1_lat", lat, 9);
    checkOutput("t1_diff", d, 16'h37);
    checkOutput("t1_bo", bo, 0);
    checkOutput("t1_donePulse", doneAfter, 0);

    applyStimulus(8, 16'h10, 16'h20, d, bo, lat, busyFirst, doneAfter);
    checkOutput("t2_diff", d, 16'hF0);
    checkOutput("t2_bo", bo, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t2_holdDiff", diff8, 8'hF0);
      checkOutput("t2_holdBo", bo8, 1);
    end

    applyStimulus(8, 16'h00, 16'h01, d, bo, lat, busyFirst, doneAfter);
    checkOutput("t3_diff", d, 16'hFF);
    checkOutput("t3_bo", bo, 1);
    applyStimulus(8, 16'hFF, 16'hFF, d, bo, lat, busyFirst, doneAfter);
    checkOutput("t4_diff", d, 16'h00);
    checkOutput("t4_bo", bo, 0);

    // start held high through a whole run must not disturb it
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(negedge clk);
    lat = 1;
    checkOutput("bs_busy", busy8, 1);
    a8 = 8'h00; b8 = 8'h00;
    while (!done8 && lat < 200) begin @(negedge clk); lat++; end
    checkOutput("bs_lat1", lat, 9);
    checkOutput("bs_diff1", diff8, 8'h7F);
    checkOutput("bs_bo1", bo8, 0);
    @(negedge clk);
    checkOutput("bs_idleBusy", busy8, 0);
    checkOutput("bs_holdDiff", diff8, 8'h7F);
    @(negedge clk);
    checkOutput("bs_accept", busy8, 1);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 200) begin @(negedge clk); lat++; end
    checkOutput("bs_lat2", lat, 9);
    checkOutput("bs_diff2", diff8, 8'h00);
    checkOutput("bs_bo2", bo8, 0);

    // Reset in the middle of RUN
    applyStimulus(8, 16'h33, 16'h11, d, bo, lat, busyFirst, doneAfter);
    checkOutput("rr_pre", d, 16'h22);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rr_busy", busy8, 0);
    checkOutput("rr_done", done8, 0);
    checkOutput("rr_diff", diff8, 0);
    checkOutput("rr_bo", bo8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8, 16'h09, 16'h03, d, bo, lat, busyFirst, doneAfter);
    checkOutput("rr_lat", lat, 9);
    checkOutput("rr_diff2", d, 16'h06);
    checkOutput("rr_bo2", bo, 0);

    // Random operands against plain modular arithmetic
    for (int pass = 0; pass < 2; pass++) begin
      int w;
      w = (pass == 0) ? 8 : 16;
      mask = (1 << w) - 1;
      for (int i = 0; i < 1000; i++) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        if (i % 50 == 0) bv = av;
        if (i % 50 == 1) bv = '0;
        ai = int'(av) & mask;
        bi = int'(bv) & mask;
        expDiff = (ai - bi + (1 << w)) % (1 << w);
        applyStimulus(w, av, bv, d, bo, lat, busyFirst, doneAfter);
        checkOutput("rnd_lat", lat, w + 1);
        checkOutput("rnd_diff", d, expDiff);
        checkOutput("rnd_bo", bo, (ai < bi) ? 1 : 0);
        checkOutput("rnd_donePulse", doneAfter, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
